// File: rtl/stopwatch_ctrl_multi.sv
// Stopwatch/timer controller: run/pause/done FSM driving inc/dec strobes
// into NF cascaded field counters, with lap hold, clear and overflow flag.
//
// Ports:
//   i_clk, i_rstn          clock, async active-low reset
//   i_tick                 base-rate tick into field 0
//   i_start_stop           pulse: start / pause / resume
//   i_lap                  pulse: toggle lap display hold
//   i_clear                pulse: request counter clear
//   i_mode                 0 count up, 1 count down (latched on start)
//   i_carry[NF]            field k wraps max->0 on this inc
//   i_borrow[NF]           field k wraps 0->max on this dec
//   i_zero                 all fields zero
//   o_inc[NF], o_dec[NF]   per-field strobes
//   o_clr                  registered clear pulse
//   o_lap_hold             display frozen on lap value
//   o_done                 countdown reached zero (1-cycle pulse)
//   o_ovf                  sticky top-field wrap in up mode
//   o_state                00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
module stopwatch_ctrl_multi #(
  parameter int NF = 4
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_tick,
  input  logic          i_start_stop,
  input  logic          i_lap,
  input  logic          i_clear,
  input  logic          i_mode,
  input  logic [NF-1:0] i_carry,
  input  logic [NF-1:0] i_borrow,
  input  logic          i_zero,
  output logic [NF-1:0] o_inc,
  output logic [NF-1:0] o_dec,
  output logic          o_clr,
  output logic          o_lap_hold,
  output logic          o_done,
  output logic          o_ovf,
  output logic [1:0]    o_state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  logic [1:0]    state, state_n;
  logic          r_mode, mode_n;
  logic          lap_hold, lap_n;
  logic          ovf, ovf_n;
  logic          clr, clr_n;
  logic          done, done_n;
  logic          run;
  logic          hit_zero;
  logic [NF-1:0] inc_src;
  logic [NF-1:0] dec_src;

  // top-field borrow has no further field to feed
  logic unused_borrow;
  assign unused_borrow = i_borrow[NF-1];

  assign run = (state == RUN);

  // a down-count tick that lands on zero stops instead of decrementing
  assign hit_zero = r_mode & i_tick & i_zero;

  always_comb begin
    inc_src    = '0;
    dec_src    = '0;
    inc_src[0] = i_tick;
    dec_src[0] = i_tick;
    for (int k = 1; k < NF; k++) begin
      inc_src[k] = i_carry[k-1];
      dec_src[k] = i_borrow[k-1];
    end
  end

  assign o_inc = (run & ~r_mode) ? inc_src : '0;
  assign o_dec = (run & r_mode & ~hit_zero) ? dec_src : '0;

  always_comb begin
    state_n = state;
    mode_n  = r_mode;
    lap_n   = lap_hold;
    ovf_n   = ovf;
    clr_n   = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_clear) begin
          clr_n = 1'b1;
          lap_n = 1'b0;
          ovf_n = 1'b0;
        end else if (i_start_stop && !(i_mode && i_zero)) begin
          state_n = RUN;
          mode_n  = i_mode;
        end
      end
      RUN: begin
        if (o_inc[NF-1] & i_carry[NF-1])
          ovf_n = 1'b1;
        if (hit_zero) begin
          state_n = DONE;
          done_n  = 1'b1;
          lap_n   = 1'b0;
        end else if (i_start_stop) begin
          state_n = PAUSE;
        end else if (i_lap) begin
          lap_n = ~lap_hold;
        end
      end
      PAUSE: begin
        if (i_clear) begin
          state_n = IDLE;
          clr_n   = 1'b1;
          lap_n   = 1'b0;
          ovf_n   = 1'b0;
        end else if (i_start_stop) begin
          state_n = RUN;
        end else if (i_lap) begin
          lap_n = 1'b0;
        end
      end
      DONE: begin
        if (i_clear) begin
          state_n = IDLE;
          clr_n   = 1'b1;
          lap_n   = 1'b0;
          ovf_n   = 1'b0;
        end else if (i_start_stop) begin
          state_n = IDLE;
          lap_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      r_mode   <= 1'b0;
      lap_hold <= 1'b0;
      ovf      <= 1'b0;
      clr      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      r_mode   <= mode_n;
      lap_hold <= lap_n;
      ovf      <= ovf_n;
      clr      <= clr_n;
      done     <= done_n;
    end
  end

  assign o_clr      = clr;
  assign o_lap_hold = lap_hold;
  assign o_done     = done;
  assign o_ovf      = ovf;
  assign o_state    = state;

endmodule
